// File: rtl/morse_keyer.sv
// morse_keyer: straight-key front end for the Morse letter decoder.
// Turns one raw, bouncy push button into single-cycle dot / dash / send pulses,
// timed purely by press duration and release gap in clk cycles.
//
// Optional feature: define MORSE_KEYER_WORD_GAP_EN to add the space output and
// the WORD state (a second, longer release gap after send fires space).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   key        raw button, asynchronous to clk, pressed = 1
//   dot        1-cycle pulse, short press completed
//   dash       1-cycle pulse, long press completed
//   send       1-cycle pulse, letter gap elapsed after at least one symbol
//   key_level  debounced key level (LED)
//   sym_cnt    symbols in the current letter, saturates at 7
//   space      1-cycle pulse, word gap elapsed after send (feature only)
module morse_keyer #(
    parameter int unsigned DEBOUNCE_CYC   = 1000000,
    parameter int unsigned DASH_CYC       = 20000000,
    parameter int unsigned LETTER_GAP_CYC = 40000000,
    parameter int unsigned WORD_GAP_CYC   = 100000000,
    parameter int unsigned CNT_W          = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic       dot,
    output logic       dash,
    output logic       send,
    output logic       key_level,
    output logic [2:0] sym_cnt
`ifdef MORSE_KEYER_WORD_GAP_EN
    ,
    output logic       space
`endif
);

    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DashLim  = CNT_W'(DASH_CYC);
    localparam logic [CNT_W-1:0] LgapLast = CNT_W'(LETTER_GAP_CYC - 1);
`ifdef MORSE_KEYER_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WgapLast = CNT_W'(WORD_GAP_CYC - 1);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StGap
`ifdef MORSE_KEYER_WORD_GAP_EN
        ,
        StWord
`endif
    } state_t;

    // Synchronizer and debounce
    logic             key_meta, key_s;
    logic             key_level_q, key_level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

    // FSM and counters
    state_t           state_q, state_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

    // Registered outputs
    logic       dot_q, dot_d;
    logic       dash_q, dash_d;
    logic       send_q, send_d;
    logic [2:0] sym_cnt_q, sym_cnt_d;
`ifdef MORSE_KEYER_WORD_GAP_EN
    logic       space_q, space_d;
`endif

    // Counter only runs while the synchronized key disagrees with the debounced
    // level, so any bounce shorter than DEBOUNCE_CYC restarts it from zero.
    always_comb begin
        db_cnt_d    = '0;
        key_level_d = key_level_q;
        if (key_s != key_level_q) begin
            if (db_cnt_q == DbLast) begin
                key_level_d = ~key_level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // State register (also holds synchronizer, debounce and output flops)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta    <= 1'b0;
            key_s       <= 1'b0;
            key_level_q <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= StIdle;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            dot_q       <= 1'b0;
            dash_q      <= 1'b0;
            send_q      <= 1'b0;
            sym_cnt_q   <= 3'd0;
`ifdef MORSE_KEYER_WORD_GAP_EN
            space_q     <= 1'b0;
`endif
        end else begin
            key_meta    <= key;
            key_s       <= key_meta;
            key_level_q <= key_level_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            dot_q       <= dot_d;
            dash_q      <= dash_d;
            send_q      <= send_d;
            sym_cnt_q   <= sym_cnt_d;
`ifdef MORSE_KEYER_WORD_GAP_EN
            space_q     <= space_d;
`endif
        end
    end

    // Next-state logic. A rising key_level always wins over an expiring gap.
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                gap_cnt_d = '0;
                if (key_level_q) begin
                    state_d     = StPress;
                    press_cnt_d = CNT_W'(1);
                end
            end
            StPress: begin
                if (key_level_q) begin
                    if (press_cnt_q < DashLim) begin
                        press_cnt_d = press_cnt_q + 1'b1;
                    end
                end else begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                if (key_level_q) begin
                    state_d     = StPress;
                    press_cnt_d = CNT_W'(1);
                end else if (gap_cnt_q == LgapLast) begin
`ifdef MORSE_KEYER_WORD_GAP_EN
                    // Word gap is timed from send, so restart the count here.
                    state_d   = StWord;
                    gap_cnt_d = '0;
`else
                    state_d   = StIdle;
                    gap_cnt_d = '0;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`ifdef MORSE_KEYER_WORD_GAP_EN
            StWord: begin
                if (key_level_q) begin
                    state_d     = StPress;
                    press_cnt_d = CNT_W'(1);
                end else if (gap_cnt_q == WgapLast) begin
                    state_d   = StIdle;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output logic: pulse next-values decoded from the transitions above.
    always_comb begin
        dot_d  = 1'b0;
        dash_d = 1'b0;
        send_d = 1'b0;
`ifdef MORSE_KEYER_WORD_GAP_EN
        space_d = 1'b0;
        if (state_q == StWord && !key_level_q && gap_cnt_q == WgapLast) begin
            space_d = 1'b1;
        end
`endif
        if (state_q == StPress && !key_level_q) begin
            if (press_cnt_q >= DashLim) begin
                dash_d = 1'b1;
            end else begin
                dot_d = 1'b1;
            end
        end
        if (state_q == StGap && !key_level_q && gap_cnt_q == LgapLast) begin
            send_d = 1'b1;
        end
        // Cleared the cycle after send so the decoder can still see the count.
        sym_cnt_d = sym_cnt_q;
        if (send_q) begin
            sym_cnt_d = 3'd0;
        end else if ((dot_d || dash_d) && sym_cnt_q != 3'd7) begin
            sym_cnt_d = sym_cnt_q + 3'd1;
        end
    end

    assign dot       = dot_q;
    assign dash      = dash_q;
    assign send      = send_q;
    assign key_level = key_level_q;
    assign sym_cnt   = sym_cnt_q;
`ifdef MORSE_KEYER_WORD_GAP_EN
    assign space     = space_q;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with short timing parameters.
// A key held high for H raw cycles gives H debounced cycles; its symbol pulse
// appears 7 cycles after release (H+7 after the press starts) and send 40
// cycles after that symbol.
module tb_morse_keyer;

    localparam int unsigned DEB  = 4;
    localparam int unsigned DASH = 20;
    localparam int unsigned LGAP = 40;
    localparam int unsigned WGAP = 100;

    logic       clk;
    logic       reset;
    logic       key;
    logic       dot, dash, send, key_level;
    logic [2:0] sym_cnt;
`ifdef MORSE_KEYER_WORD_GAP_EN
    logic       space;
    int         n_space, t_space;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0;
    int n_dot, n_dash, n_send, n_kl;
    int t_dot, t_dash, t_send;
    int sym_max, sym_at_sym;
    int viol = 0;
    logic prev_pulse = 1'b0;
    logic prev_kl;

    morse_keyer #(
        .DEBOUNCE_CYC  (DEB),
        .DASH_CYC      (DASH),
        .LETTER_GAP_CYC(LGAP),
        .WORD_GAP_CYC  (WGAP),
        .CNT_W         (27)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key      (key),
        .dot      (dot),
        .dash     (dash),
        .send     (send),
        .key_level(key_level),
        .sym_cnt  (sym_cnt)
`ifdef MORSE_KEYER_WORD_GAP_EN
        ,
        .space    (space)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clr();
        n_dot = 0; n_dash = 0; n_send = 0; n_kl = 0;
        t_dot = -1; t_dash = -1; t_send = -1;
        sym_max = 0; sym_at_sym = -1;
        prev_kl = key_level;
`ifdef MORSE_KEYER_WORD_GAP_EN
        n_space = 0; t_space = -1;
`endif
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            @(posedge clk);
            #1;
            cyc++;
            p = int'(dot) + int'(dash) + int'(send);
`ifdef MORSE_KEYER_WORD_GAP_EN
            p = p + int'(space);
            if (space === 1'b1) begin n_space++; t_space = cyc; end
`endif
            if (p > 1) viol++;
            if (p > 0 && prev_pulse) viol++;
            prev_pulse = (p > 0);
            if (dot === 1'b1) begin n_dot++; t_dot = cyc; sym_at_sym = int'(sym_cnt); end
            if (dash === 1'b1) begin n_dash++; t_dash = cyc; sym_at_sym = int'(sym_cnt); end
            if (send === 1'b1) begin n_send++; t_send = cyc; end
            if (key_level !== prev_kl) n_kl++;
            prev_kl = key_level;
            if (int'(sym_cnt) > sym_max) sym_max = int'(sym_cnt);
        end
    endtask

    task automatic press(input int h, input int low);
        key = 1'b1;
        c0 = cyc;
        run(h);
        key = 1'b0;
        run(low);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key = 1'b0;
        run(3);
        total++; if (dot !== 1'b0) begin bad++; $display("FAIL reset_dot got=%b want=0", dot); end
        total++; if (dash !== 1'b0) begin bad++; $display("FAIL reset_dash got=%b want=0", dash); end
        total++; if (send !== 1'b0) begin bad++; $display("FAIL reset_send got=%b want=0", send); end
        total++; if (key_level !== 1'b0) begin bad++; $display("FAIL reset_key_level got=%b want=0", key_level); end
        total++; if (sym_cnt !== 3'd0) begin bad++; $display("FAIL reset_sym_cnt got=%0d want=0", sym_cnt); end
        reset = 1'b0;
        run(2);
    endtask

    task automatic test_dot_send();
        clr();
        press(10, 60);
        total++; if (n_dot != 1) begin bad++; $display("FAIL t1_dot_count got=%0d want=1", n_dot); end
        total++; if (n_dash != 0) begin bad++; $display("FAIL t1_dash_count got=%0d want=0", n_dash); end
        total++; if (t_dot != c0 + 17) begin bad++; $display("FAIL t1_dot_time got=%0d want=%0d", t_dot, c0 + 17); end
        total++; if (n_send != 1) begin bad++; $display("FAIL t1_send_count got=%0d want=1", n_send); end
        total++; if (t_send != c0 + 57) begin bad++; $display("FAIL t1_send_time got=%0d want=%0d", t_send, c0 + 57); end
        total++; if (sym_at_sym != 1) begin bad++; $display("FAIL t1_sym_at_dot got=%0d want=1", sym_at_sym); end
        total++; if (sym_cnt !== 3'd0) begin bad++; $display("FAIL t1_sym_after_send got=%0d want=0", sym_cnt); end
    endtask

    task automatic test_dash_threshold();
        clr();
        press(30, 60);
        total++; if (n_dash != 1 || n_dot != 0) begin bad++; $display("FAIL t2_long_dash got=%0d/%0d want=1/0", n_dash, n_dot); end
        total++; if (t_dash != c0 + 37) begin bad++; $display("FAIL t2_long_time got=%0d want=%0d", t_dash, c0 + 37); end
        clr();
        press(20, 60);
        total++; if (n_dash != 1 || n_dot != 0) begin bad++; $display("FAIL t2_press20 got=%0d/%0d want=1/0", n_dash, n_dot); end
        clr();
        press(19, 60);
        total++; if (n_dot != 1 || n_dash != 0) begin bad++; $display("FAIL t2_press19 got=%0d/%0d want=1/0", n_dot, n_dash); end
        total++; if (t_dot != c0 + 26) begin bad++; $display("FAIL t2_press19_time got=%0d want=%0d", t_dot, c0 + 26); end
    endtask

    task automatic test_bounce();
        clr();
        for (int i = 0; i < 30; i++) begin
            key = ((i / 2) % 2 == 0);
            run(1);
        end
        key = 1'b0;
        run(60);
        total++; if (n_kl != 0) begin bad++; $display("FAIL t3_key_level_changes got=%0d want=0", n_kl); end
        total++; if (n_dot + n_dash + n_send != 0) begin bad++; $display("FAIL t3_pulses got=%0d want=0", n_dot + n_dash + n_send); end
    endtask

    task automatic test_sequence();
        clr();
        c0 = cyc;
        key = 1'b1; run(10);
        key = 1'b0; run(20);
        key = 1'b1; run(30);
        key = 1'b0; run(20);
        key = 1'b1; run(10);
        key = 1'b0; run(60);
        total++; if (n_dot != 2) begin bad++; $display("FAIL t4_dots got=%0d want=2", n_dot); end
        total++; if (n_dash != 1) begin bad++; $display("FAIL t4_dashes got=%0d want=1", n_dash); end
        total++; if (t_dash != c0 + 67) begin bad++; $display("FAIL t4_dash_time got=%0d want=%0d", t_dash, c0 + 67); end
        total++; if (n_send != 1) begin bad++; $display("FAIL t4_sends got=%0d want=1", n_send); end
        total++; if (t_send != c0 + 137) begin bad++; $display("FAIL t4_send_time got=%0d want=%0d", t_send, c0 + 137); end
        total++; if (sym_max != 3) begin bad++; $display("FAIL t4_sym_max got=%0d want=3", sym_max); end
    endtask

    task automatic test_gap_boundary();
        // Raw gap of 40: key_level rises exactly when gap_cnt is 39, press wins.
        clr();
        c0 = cyc;
        key = 1'b1; run(10);
        key = 1'b0; run(40);
        key = 1'b1; run(10);
        total++; if (n_send != 0) begin bad++; $display("FAIL t5_no_send got=%0d want=0", n_send); end
        key = 1'b0; run(60);
        total++; if (n_dot != 2) begin bad++; $display("FAIL t5_dots got=%0d want=2", n_dot); end
        total++; if (sym_at_sym != 2) begin bad++; $display("FAIL t5_sym_cnt got=%0d want=2", sym_at_sym); end
        total++; if (n_send != 1 || t_send != c0 + 107) begin bad++; $display("FAIL t5_send got=%0d@%0d want=1@%0d", n_send, t_send, c0 + 107); end
        // Raw gap of 41: the gap expires one cycle before the press arrives.
        clr();
        c0 = cyc;
        key = 1'b1; run(10);
        key = 1'b0; run(41);
        key = 1'b1; run(10);
        key = 1'b0; run(60);
        total++; if (n_send != 2) begin bad++; $display("FAIL t5b_sends got=%0d want=2", n_send); end
        total++; if (t_dot != c0 + 68 || sym_at_sym != 1) begin bad++; $display("FAIL t5b_new_letter got=%0d/%0d want=%0d/1", t_dot, sym_at_sym, c0 + 68); end
    endtask

    task automatic test_reset_mid();
        clr();
        press(10, 20);
        key = 1'b1;
        run(15);
        #2;
        reset = 1'b1;
        #1;
        total++; if ({dot, dash, send, key_level} !== 4'b0000) begin bad++; $display("FAIL t6_async_outputs got=%b want=0000", {dot, dash, send, key_level}); end
        total++; if (sym_cnt !== 3'd0) begin bad++; $display("FAIL t6_async_sym got=%0d want=0", sym_cnt); end
        key = 1'b0;
        run(3);
        reset = 1'b0;
        clr();
        run(60);
        total++; if (n_dot + n_dash + n_send != 0) begin bad++; $display("FAIL t6_discarded got=%0d want=0", n_dot + n_dash + n_send); end
        // Key held across reset: the press counts from reset release.
        clr();
        key = 1'b1;
        run(5);
        #2;
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        c0 = cyc;
        run(10);
        key = 1'b0;
        run(60);
        total++; if (n_dot != 1 || t_dot != c0 + 17) begin bad++; $display("FAIL t6_held_dot got=%0d@%0d want=1@%0d", n_dot, t_dot, c0 + 17); end
        total++; if (n_send != 1 || sym_at_sym != 1) begin bad++; $display("FAIL t6_held_send got=%0d/%0d want=1/1", n_send, sym_at_sym); end
    endtask

`ifdef MORSE_KEYER_WORD_GAP_EN
    task automatic test_word_gap();
        clr();
        press(10, 160);
        total++; if (n_send != 1 || t_send != c0 + 57) begin bad++; $display("FAIL t7_send got=%0d@%0d want=1@%0d", n_send, t_send, c0 + 57); end
        total++; if (n_space != 1) begin bad++; $display("FAIL t7_space_count got=%0d want=1", n_space); end
        total++; if (t_space != c0 + 157) begin bad++; $display("FAIL t7_space_time got=%0d want=%0d", t_space, c0 + 157); end
    endtask
`endif

    initial begin
        test_reset();
        test_dot_send();
        test_dash_threshold();
        test_bounce();
        test_sequence();
        test_gap_boundary();
        test_reset_mid();
`ifdef MORSE_KEYER_WORD_GAP_EN
        test_word_gap();
`endif
        total++; if (viol != 0) begin bad++; $display("FAIL pulse_exclusive got=%0d want=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
